cmv300_sensor_emu: RTL
======================

CMV300_SENSOR_EMU -- requirements
Module: cmv300_sensor_emu

Interface
REQ-001 SHALL have parameter COLS, default 648, pixels per line (1..1024).
REQ-002 SHALL have parameter ROWS, default 488, lines per frame (1..512).
REQ-003 SHALL have parameter FOT, default 32, frame-overhead cycles from request to first line (>=1).
REQ-004 SHALL have parameter LINE_GAP, default 16, idle cycles between lines with lval low (>=1).
REQ-005 SHALL have port i_clk, input, 1, emulated sensor clock; all logic on rising edge. o_data/o_lval/o_dval change only on rising edge so the capture side samples on the falling edge.
REQ-006 SHALL have port line_counter_rst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port i_sys_res_n, input, 1, sensor reset, active-low, synchronous.
REQ-008 SHALL have port i_frame_req, input, 1, frame request; rising edge starts a frame.
REQ-009 SHALL have port i_pattern_sel, input, 2, test pattern select, sampled at frame start.
REQ-010 SHALL have port o_data, output, 10, pixel data.
REQ-011 SHALL have port o_lval, output, 1, line valid.
REQ-012 SHALL have port o_dval, output, 1, data valid.
REQ-013 SHALL have port o_busy, output, 1, high from frame start until frame end.
REQ-014 SHALL have port o_frame_done, output, 1, one-cycle pulse at frame end.
REQ-015 SHALL have port o_overrun, output, 1, sticky: request edge received while busy.
REQ-016 SHALL have port o_frame_cnt, output, 8, completed-frame count.

Function
REQ-017 SHALL register i_frame_req each cycle; edge = current 1 and registered previous 0.
REQ-018 SHALL implement states IDLE, FOT, LINE, GAP, DONE.
REQ-019 IDLE: edge -> FOT; latch i_pattern_sel; clear row/col/delay counters; o_busy=1 from next cycle.
REQ-020 FOT: count FOT cycles, then -> LINE; the first o_lval=1 cycle is exactly FOT+1 rising edges after the edge-detect edge.
REQ-021 LINE: o_lval=o_dval=1 for exactly COLS cycles, col 0..COLS-1; at col==COLS-1: row==ROWS-1 -> DONE, else row+1 and -> GAP.
REQ-022 GAP: o_lval=o_dval=0 for exactly LINE_GAP cycles, then -> LINE with col=0.
REQ-023 DONE: one cycle; o_frame_done=1; o_busy=0; o_frame_cnt+1, wrapping 255->0; -> IDLE.
REQ-024 Pattern 0: o_data=col[9:0]. 1: o_data={1'b0,row[8:0]}. 2: o_data=10'h3FF if col[3]^row[3] else 10'h000. 3: o_data=(col+o_frame_cnt) mod 1024.
REQ-025 o_data SHALL be 10'h000 whenever o_lval=0.
REQ-026 Edge while state!=IDLE (DONE included) SHALL be ignored and set o_overrun; frame in progress unaffected.
REQ-027 An edge in the cycle IDLE is re-entered from DONE SHALL start a new frame; o_overrun unchanged.
REQ-028 A high level held on i_frame_req SHALL NOT start a second frame; a new 0->1 transition is required.
REQ-029 i_pattern_sel changes mid-frame SHALL have no effect until the next frame start.
REQ-030 i_sys_res_n=0 SHALL force IDLE at the next edge; o_lval/o_dval/o_busy/o_frame_done=0, o_data=0, o_overrun=0, o_frame_cnt=0; edges are ignored while low.
REQ-031 i_sys_res_n=0 mid-frame SHALL abort with no o_frame_done pulse.

Reset
REQ-032 line_counter_rst=1 SHALL immediately force IDLE, o_data=0, o_lval=0, o_dval=0, o_busy=0, o_frame_done=0, o_overrun=0, o_frame_cnt=0; registered i_frame_req=0.
REQ-033 After line_counter_rst release, i_frame_req already high SHALL count as an edge on the first clock.

Verification (COLS=8, ROWS=4, FOT=3, LINE_GAP=2 unless stated)
REQ-034 Pattern 0, one request pulse -> first lval 4 cycles after edge; 4 lines of 8 cycles, data 0..7; 2-cycle gaps; 32 dval cycles total; one o_frame_done; o_frame_cnt=1.
REQ-035 Pattern 3, three back-to-back frames -> frame k line data k..k+7; o_frame_cnt 3; o_overrun=0.
REQ-036 Second edge during line 2 -> frame completes unchanged; o_overrun=1 until reset; no extra frame.
REQ-037 i_sys_res_n low for 1 cycle during line 1 -> lval low next cycle; no o_frame_done; o_frame_cnt=0; new request gives a full frame.
REQ-038 line_counter_rst asserted mid-GAP between clock edges -> all outputs 0 without a clock; after release, i_frame_req held high starts a frame.
REQ-039 Defaults (648x488), pattern 2 -> 488 lval pulses of 648 dval cycles each; data alternates 0/3FF every 8 columns, phase flips every 8 rows.

Source files
------------

// File: rtl/cmv300_sensor_emu.sv
`default_nettype none
// cmv300_sensor_emu : CMV300 parallel-output sensor emulator with test patterns -- rev 1.0
// Frame request edge -> frame overhead -> ROWS lines of COLS pixels separated by idle gaps.
module cmv300_sensor_emu #(
  parameter int COLS     = 648,
  parameter int ROWS     = 488,
  parameter int FOT      = 32,
  parameter int LINE_GAP = 16
) (
  input  logic       i_clk,
  input  logic       line_counter_rst,
  input  logic       i_sys_res_n,
  input  logic       i_frame_req,
  input  logic [1:0] i_pattern_sel,
  output logic [9:0] o_data,
  output logic       o_lval,
  output logic       o_dval,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_overrun,
  output logic [7:0] o_frame_cnt
);

  localparam int c_DMAX = (FOT > LINE_GAP) ? FOT : LINE_GAP;
  localparam int c_DW   = $clog2(c_DMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FOT  = 3'd1,
    S_LINE = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_req_d;
  logic              w_edge;
  logic [1:0]        r_pat;
  logic [9:0]        r_col, w_col_nxt;
  logic [8:0]        r_row, w_row_nxt;
  logic [c_DW-1:0]   r_dly, w_dly_nxt;
  logic              r_overrun;
  logic [7:0]        r_frame_cnt;
  logic              w_lval;
  logic [9:0]        w_pix;

  assign w_edge = i_frame_req & ~r_req_d;

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_dly_nxt   = r_dly;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_state_nxt = S_FOT;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
          w_dly_nxt   = '0;
        end
      end
      // Overhead phase spans FOT+1 cycles so the first pixel lands FOT+1 edges after the request edge
      S_FOT: begin
        if (r_dly == c_DW'(FOT)) begin
          w_state_nxt = S_LINE;
          w_col_nxt   = '0;
        end else begin
          w_dly_nxt = r_dly + 1'b1;
        end
      end
      S_LINE: begin
        if (r_col == 10'(COLS - 1)) begin
          if (r_row == 9'(ROWS - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_GAP;
            w_row_nxt   = r_row + 9'd1;
            w_dly_nxt   = '0;
          end
        end else begin
          w_col_nxt = r_col + 10'd1;
        end
      end
      S_GAP: begin
        if (r_dly == c_DW'(LINE_GAP - 1)) begin
          w_state_nxt = S_LINE;
          w_col_nxt   = '0;
        end else begin
          w_dly_nxt = r_dly + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge line_counter_rst) begin
    if (line_counter_rst) begin
      r_state     <= S_IDLE;
      r_req_d     <= 1'b0;
      r_pat       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_dly       <= '0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_req_d <= i_frame_req;
      if (!i_sys_res_n) begin
        r_state     <= S_IDLE;
        r_pat       <= '0;
        r_col       <= '0;
        r_row       <= '0;
        r_dly       <= '0;
        r_overrun   <= 1'b0;
        r_frame_cnt <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_col   <= w_col_nxt;
        r_row   <= w_row_nxt;
        r_dly   <= w_dly_nxt;
        if (r_state == S_IDLE && w_edge) begin
          r_pat <= i_pattern_sel;
        end
        if (r_state != S_IDLE && w_edge) begin
          r_overrun <= 1'b1;
        end
        if (r_state == S_LINE && w_state_nxt == S_DONE) begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_pix = '0;
    case (r_pat)
      2'd0:    w_pix = r_col;
      2'd1:    w_pix = {1'b0, r_row};
      2'd2:    w_pix = (r_col[3] ^ r_row[3]) ? 10'h3FF : 10'h000;
      default: w_pix = r_col + {2'b00, r_frame_cnt};
    endcase
  end

  assign w_lval       = (r_state == S_LINE);
  assign o_lval       = w_lval;
  assign o_dval       = w_lval;
  assign o_data       = w_lval ? w_pix : 10'h000;
  assign o_busy       = (r_state == S_FOT) || (r_state == S_LINE) || (r_state == S_GAP);
  assign o_frame_done = (r_state == S_DONE);
  assign o_overrun    = r_overrun;
  assign o_frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire
